// File: rtl/mole_round_scheduler.sv
// Round sequencer for the whack-a-mole game: empty-grid gap, mole cell draw,
// reaction window and a hit-driven difficulty ramp. All round timing lives here.
module mole_round_scheduler #(
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int unsigned WIN_EASY   = 100_000_000,
  parameter int unsigned WIN_HARD   = 50_000_000,
  parameter int unsigned WIN_MIN    = 20_000_000,
  parameter int unsigned WIN_STEP   = 2_000_000,
  parameter int unsigned STEP_HITS  = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic        hit,
  input  logic        miss,
  output logic [3:0]  mole_pos,
  output logic        mole_vld,
  output logic        timeout,
  output logic        game_over,
  output logic [3:0]  level,
  output logic [31:0] win_cycles
);

  localparam int unsigned HCW = (STEP_HITS > 1) ? $clog2(STEP_HITS) : 1;
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [HCW-1:0] HIT_LAST = HCW'(STEP_HITS - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_e;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     win_q, win_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      pos_q, pos_d;
  logic [HCW-1:0]  hit_cnt_q, hit_cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic            win_last;
  logic [3:0]      pos_draw;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign pos_draw = (lfsr_q[3:0] == pos_q) ? lfsr_q[3:0] + 4'd1 : lfsr_q[3:0];
  assign win_last = (cnt_q == win_q - 32'd1);

  always_comb begin
    // NOTE: every _d takes its held value first, so no path leaves a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    level_d   = level_q;
    pos_d     = pos_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = GAP;
          cnt_d     = '0;
          level_d   = '0;
          hit_cnt_d = '0;
          win_d     = mode ? WIN_HARD : WIN_EASY;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          pos_d   = pos_draw;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SHOW: begin
        // A wrong cell ends the game even if the right one was struck too.
        if (miss) begin
          state_d = OVER;
        end else if (hit) begin
          state_d = GAP;
          cnt_d   = '0;
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            level_d   = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            win_d     = (win_q >= WIN_MIN + WIN_STEP) ? win_q - WIN_STEP : WIN_MIN;
          end else begin
            hit_cnt_d = hit_cnt_q + HCW'(1);
          end
        end else if (win_last) begin
          state_d = OVER;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments only.
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      level_q   <= '0;
      pos_q     <= '0;
      hit_cnt_q <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      level_q   <= level_d;
      pos_q     <= pos_d;
      hit_cnt_q <= hit_cnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // timeout must fall in the last window cycle and be vetoed by a same-cycle
  // hit or miss, so it is decoded from the inputs rather than registered.
  assign timeout    = (state_q == SHOW) && win_last && !hit && !miss;
  assign mole_vld   = (state_q == SHOW);
  assign game_over  = (state_q == OVER);
  assign mole_pos   = pos_q;
  assign level      = level_q;
  assign win_cycles = win_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Randomized bench for mole_round_scheduler: a round-level reference model is
// compared against every output on every cycle, plus targeted scenario checks.
module tb_mole_round_scheduler;

  localparam int GAP   = 4;
  localparam int EASY  = 10;
  localparam int HARD  = 6;
  localparam int WMIN  = 4;
  localparam int WSTEP = 2;
  localparam int SHITS = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int S_IDLE = 0;
  localparam int S_GAP  = 1;
  localparam int S_SHOW = 2;
  localparam int S_OVER = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic [3:0]  mole_pos;
  logic        mole_vld;
  logic        timeout;
  logic        game_over;
  logic [3:0]  level;
  logic [31:0] win_cycles;

  mole_round_scheduler #(
    .GAP_CYCLES(GAP), .WIN_EASY(EASY), .WIN_HARD(HARD), .WIN_MIN(WMIN),
    .WIN_STEP(WSTEP), .STEP_HITS(SHITS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hit(hit), .miss(miss),
    .mole_pos(mole_pos), .mole_vld(mole_vld), .timeout(timeout),
    .game_over(game_over), .level(level), .win_cycles(win_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase plus cycles left in that phase.
  int          m_state;
  int          m_left;
  int          m_level;
  int          m_hits;
  int          m_win;
  logic [3:0]  m_pos;
  logic [15:0] m_lfsr;

  logic [3:0]  prev_seen;
  logic [15:0] seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] fb;
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
    return (v >> 1) | (fb << 15);
  endfunction

  task automatic model_reset();
    m_state   = S_IDLE;
    m_left    = 0;
    m_level   = 0;
    m_hits    = 0;
    m_win     = 0;
    m_pos     = 4'd0;
    m_lfsr    = SEED;
    prev_seen = 4'd0;
  endtask

  task automatic model_step(input logic s, input logic md, input logic h, input logic ms);
    int raw;
    case (m_state)
      S_IDLE, S_OVER: begin
        if (s) begin
          m_state = S_GAP;
          m_left  = GAP;
          m_level = 0;
          m_hits  = 0;
          m_win   = md ? HARD : EASY;
        end
      end
      S_GAP: begin
        m_left--;
        if (m_left == 0) begin
          raw = int'(m_lfsr) % 16;
          if (raw == int'(m_pos)) raw = (raw + 1) % 16;
          m_pos   = 4'(raw);
          m_state = S_SHOW;
          m_left  = m_win;
        end
      end
      S_SHOW: begin
        if (ms) begin
          m_state = S_OVER;
        end else if (h) begin
          m_state = S_GAP;
          m_left  = GAP;
          m_hits++;
          if (m_hits == SHITS) begin
            m_hits = 0;
            if (m_level < 15) m_level++;
            m_win = (m_win - WSTEP < WMIN) ? WMIN : m_win - WSTEP;
          end
        end else begin
          m_left--;
          if (m_left == 0) m_state = S_OVER;
        end
      end
      default: m_state = S_IDLE;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  // One clock cycle: drive inputs after a falling edge, compare all outputs,
  // advance the model at the rising edge.
  task automatic cycle(input logic s, input logic md, input logic h, input logic ms,
                       output logic to_o);
    logic to_exp;
    start = s; mode = md; hit = h; miss = ms;
    #1;
    to_exp = (m_state == S_SHOW) && (m_left == 1) && !h && !ms;
    check("cycle",
          64'({mole_pos, mole_vld, timeout, game_over, level, win_cycles}),
          64'({m_pos, m_state == S_SHOW, to_exp, m_state == S_OVER, 4'(m_level), 32'(m_win)}));
    to_o = timeout;
    @(posedge clk);
    model_step(s, md, h, ms);
    @(negedge clk);
    start = 1'b0; mode = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic wait_show(input logic inject, output int n);
    logic to;
    n = 0;
    while (!mole_vld && n < 64) begin
      cycle(1'b0, 1'b0, inject && ($urandom_range(0, 3) == 0),
            inject && ($urandom_range(0, 7) == 0), to);
      n++;
    end
    check("show_reached", 64'(mole_vld), 64'(1));
    if (mole_vld) begin
      check("pos_repeat", 64'(mole_pos == prev_seen), 64'(0));
      prev_seen      = mole_pos;
      seen[mole_pos] = 1'b1;
    end
  endtask

  task automatic hit_after(input int d, input logic inject);
    logic to;
    for (int k = 0; k < d; k++)
      cycle(inject && ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, to);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, to);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs",
          64'({mole_pos, mole_vld, timeout, game_over, level, win_cycles}), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic to;
    int   n;

    seen = '0;
    model_reset();
    @(negedge clk);
    check("rst_mole_pos",   64'(mole_pos),   64'(0));
    check("rst_mole_vld",   64'(mole_vld),   64'(0));
    check("rst_timeout",    64'(timeout),    64'(0));
    check("rst_game_over",  64'(game_over),  64'(0));
    check("rst_level",      64'(level),      64'(0));
    check("rst_win_cycles", 64'(win_cycles), 64'(0));
    rst_n = 1'b1;

    // Easy game, no input: gap length, window length, timeout, game over.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, to);
    wait_show(1'b0, n);
    check("gap_len", 64'(n), 64'(GAP));
    check("win_easy", 64'(win_cycles), 64'(EASY));
    n  = 0;
    to = 1'b0;
    while (!to && n < 64) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, to);
      n++;
    end
    check("timeout_cycle", 64'(n), 64'(EASY));
    check("over_after_to", 64'(game_over), 64'(1));

    // Hard game, six hits: level ramps while the window sits on its floor.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, to);
    for (int i = 0; i < 6; i++) begin
      wait_show(1'b1, n);
      hit_after($urandom_range(0, m_win - 1), 1'b1);
      if (i % 2 == 1) begin
        check("ramp_level", 64'(level), 64'((i + 1) / 2));
        check("ramp_win",   64'(win_cycles), 64'(WMIN));
      end
    end

    // Hit and miss together: miss wins, level untouched.
    wait_show(1'b0, n);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, to);
    check("hm_over",  64'(game_over), 64'(1));
    check("hm_level", 64'(level), 64'(3));

    // Hit on the last window cycle counts as a hit.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, to);
    wait_show(1'b0, n);
    repeat (EASY - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, to);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, to);
    check("last_hit_no_to", 64'(to), 64'(0));
    check("last_hit_gap",   64'({mole_vld, game_over}), 64'(0));

    // Long random run: positions never repeat back to back, all cells drawn.
    seen = '0;
    for (int r = 0; r < 2000; r++) begin
      wait_show(1'b1, n);
      hit_after($urandom_range(0, m_win - 1), 1'b1);
    end
    check("all_cells", 64'(seen), 64'(16'hFFFF));
    check("level_sat", 64'(level), 64'(15));
    check("win_floor", 64'(win_cycles), 64'(WMIN));

    // Reset mid-SHOW, then stray hits in IDLE and a stray start in SHOW.
    wait_show(1'b0, n);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, to);
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, to);
    check("idle_hit", 64'({game_over, mole_vld, level}), 64'(0));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, to);
    wait_show(1'b1, n);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, to);
    check("show_start_win", 64'(win_cycles), 64'(HARD));
    check("show_start_vld", 64'(mole_vld), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
